// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, constants and the prefetch entry type for instruction fetch
package inst_fetch_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, ROM request, prefetch buffer and redirect handling for decode
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              align_err
);
  logic [ADDR_W-1:0] pc;
  logic deq, fetch, full, empty;
  fetch_entry_t head;
  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fetch),
    .pop  (deq),
    .flush(redirect),
    .din  ('{pc: pc, inst: imem_inst}),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    deq      = if_valid & if_ready;
    fetch    = fetch_en & !redirect & (!full | deq);
    if_valid = !empty;
    if_inst  = if_valid ? head.inst : NOP_INST;
    if_pc    = if_valid ? head.pc : '0;
    imem_addr = pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      align_err <= 1'b0;
    end else begin
      pc        <= redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : fetch ? pc + PC_STEP : pc;
      align_err <= redirect & |redirect_pc[1:0];
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized ROM and stimulus checked against an in-order PC stream scoreboard
module tb_inst_fetch;
  import inst_fetch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_en = 1'b0;
  logic redirect = 1'b0;
  logic if_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_inst, if_inst, if_pc;
  logic if_valid, align_err;
  logic [31:0] rom [64];
  logic [31:0] exp_pc = '0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  assign imem_inst = rom[imem_addr[7:2]];
  inst_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .fetch_en   (fetch_en),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .align_err  (align_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_align", 32'(align_err), 32'd0);
    rst = 1'b0;
    exp_pc = 32'h0;
  endtask
  task automatic cycle(input logic fe, input logic rdy, input logic rd, input logic [31:0] tgt);
    logic held;
    logic [31:0] hpc, hinst, addr0;
    fetch_en = fe;
    if_ready = rdy;
    redirect = rd;
    redirect_pc = tgt;
    held = if_valid & !rdy & !rd;
    hpc = if_pc;
    hinst = if_inst;
    addr0 = imem_addr;
    if (if_valid && rdy) begin
      chk("order_pc", if_pc, exp_pc);
      chk("order_inst", if_inst, rom[exp_pc[7:2]]);
      exp_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    chk("align_err", 32'(align_err), 32'(rd && tgt[1:0] != 2'b00));
    chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
    if (rd) begin
      exp_pc = {tgt[31:2], 2'b00};
      chk("redir_addr", imem_addr, exp_pc);
      chk("redir_flush", 32'(if_valid), 32'd0);
    end else begin
      if (fe) chk("live", 32'(if_valid), 32'd1);
      else chk("frozen", imem_addr, addr0);
      if (held) begin
        chk("hold_pc", if_pc, hpc);
        chk("hold_inst", if_inst, hinst);
      end
    end
    if (!if_valid) begin
      chk("idle_pc", if_pc, 32'd0);
      chk("idle_inst", if_inst, 32'd0);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    do_reset();
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t1_head", if_pc, 32'h14);
    chk("t1_addr", imem_addr, 32'h18);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_addr", imem_addr, 32'h8);
    chk("t2_head", if_pc, 32'h0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h10);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3_pc", if_pc, 32'h10);
    chk("t3_inst", if_inst, rom[4]);
    cycle(1'b1, 1'b1, 1'b1, 32'h13);
    chk("t4_addr", imem_addr, 32'h10);
    chk("t4_err", 32'(align_err), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_err_clr", 32'(align_err), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t6_drained", 32'(if_valid), 32'd0);
    repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch front end and requester side of the instruction ROM interface.
- Holds the PC and drives a word-aligned byte address to the combinational instruction ROM.
- Captures the returned word with its PC into a small prefetch buffer.
- Presents {pc, inst} to decode over a valid/ready handshake; branch/jump redirects flush the buffer and retarget the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (must be word aligned)
DEPTH, 2, prefetch buffer entries (power of 2, >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
imem_addr  out  32  byte address to ROM; bits [1:0] always 0
imem_inst  in  32  ROM data for imem_addr, valid same cycle (combinational ROM)
fetch_en  in  1  1 = fetch allowed; 0 = no new fetches, buffer still drains
redirect  in  1  branch/jump taken this cycle
redirect_pc  in  32  redirect target byte address
if_valid  out  1  buffer head valid
if_ready  in  1  decode accepts head
if_inst  out  32  head instruction (0 when if_valid=0)
if_pc  out  32  head PC (0 when if_valid=0)
align_err  out  1  one-cycle pulse: last redirect target had bits [1:0] != 0

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, buffer count=0, pointers=0, align_err=0. Therefore if_valid=0, if_inst=0, if_pc=0, imem_addr=RESET_PC. Reset overrides every other input.
- imem_addr = pc (registered), with no combinational path from inputs.
- deq = if_valid & if_ready.
- fetch = fetch_en & !redirect & (count<DEPTH | deq). On fetch, push {pc, imem_inst} and set pc <= pc+4. Addition is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Count update: +1 on fetch only; -1 on deq only; unchanged on both or neither. Full with deq permits a same-cycle fetch. Never overflows or underflows.
- Redirect has priority over fetch and deq:
  - count <= 0 (flush), pc <= {redirect_pc[31:2], 2'b00}, no push that cycle.
  - Head visible during the redirect cycle may still handshake; it is discarded either way.
  - align_err <= (redirect_pc[1:0] != 0) on the next edge; otherwise align_err <= 0.
- Latency:
  - First if_valid one cycle after rst deasserts (if fetch_en=1).
  - Redirect asserted in cycle N: imem_addr=target in N+1, if_valid with if_pc=target in N+2.
  - Steady-state throughput is one instruction per cycle with if_ready held at 1.
- Ordering: instructions leave in strict PC order with no loss and no duplication across any stall pattern.
- fetch_en=0: pc frozen, no pushes, deq continues. A redirect is still honoured.
- if_inst and if_pc remain stable while if_valid=1 & if_ready=0.
- No address range check: ROM aliasing above 0xFC is the ROM's concern.

Decomposition:
- Shared package: INST_W=32, ADDR_W=32, NOP_INST=32'h0, default RESET_PC, PC_STEP=4.
- One sub-module: inst_fifo, a synchronous FIFO of {pc, inst} with push, pop, flush, count, full, empty. Flush has priority over push and pop.
- inst_fetch contains the PC register, fetch/redirect control and align_err.

Test Plan:
1. ROM words 0..4 loaded, fetch_en=1, if_ready=1, release rst -> if_valid=1 from cycle 1; if_pc 0x0,0x4,0x8,0xC,0x10 on consecutive cycles with if_inst = ROM words 0..4.
2. if_ready=0 for 5 cycles after first valid -> buffer fills (DEPTH=2), imem_addr holds 0x8, if_pc stays 0x0. Release -> 0x0,0x4,0x8 in order, one per cycle, no duplicates.
3. Buffer full, if_ready=0, redirect=1 with redirect_pc=0x10 -> next cycle if_valid=0 and imem_addr=0x10; following cycle if_pc=0x10, if_inst=ROM word 4.
4. redirect_pc=0x13 -> imem_addr=0x10 next cycle, align_err=1 for exactly that one cycle, then 0.
5. rst asserted mid-stream with buffer full -> next cycle if_valid=0, if_inst=0, imem_addr=RESET_PC, align_err=0. Stream restarts at RESET_PC.
6. Redirect to 0xFFFF_FFFC, if_ready=1 -> if_pc 0xFFFF_FFFC then 0x0000_0000. With fetch_en=0 for 3 cycles, imem_addr is frozen and the buffer drains to if_valid=0.
